uart_ctrl_fifo: RTL and testbench

Parametrised successor to the team's 8250-style serial control block. Fully synchronous CPU register interface with an RX FIFO, a TX holding register with a load handshake to the transmitter, modem control and status registers, and a maskable interrupt. It sits between the CPU bus and the serial shifter/receiver blocks.

---
 rtl/uart_ctrl_fifo.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_ctrl_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: CPU-facing serial control block.
// Contents: RX FIFO, TX holding register with load/ack handshake,
// modem control (MCR) and modem status (MSR) registers, line status (LSR)
// and a maskable interrupt.
// Optional feature macro: UART_LOOPBACK_EN (MCR bit4 internal loopback).
module uart_ctrl_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              data_en,
  input  logic              cts,
  input  logic              dsr,
  input  logic              dcd,
  input  logic              ri,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  input  logic              tx_ack,
  output logic              rts,
  output logic              dtr,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // bus strobes
  logic        w_rd_act, w_wr_act, w_wr_stb, w_rd_end;
  logic        r_rd_act_d, r_wr_act_d;
  logic [1:0]  r_rd_addr;

  // registers
  logic [3:0]  r_mcr;          // {msr_ie, rx_ie, rts, dtr}
  logic        w_loop;
  logic [3:0]  r_sync [SYNC_STAGES];
  logic [3:0]  w_modem_raw, w_stat, r_stat_prev, w_delta_ev, r_delta;
  logic [7:0]  w_msr8;
  logic [4:0]  w_lsr, w_mcr_rd;
  logic        r_rx_ovr, r_tx_ovr, r_tx_load, r_lb_push, r_irq;
  logic [DATA_W-1:0] r_thr, w_rdata;

  // fifo
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic        w_empty, w_full, w_push_req, w_push, w_pop, w_rx_ovr_ev;
  logic [DATA_W-1:0] w_push_data;
  logic        w_thr_wr, w_tx_ovr_ev, w_msr_clr, w_lsr_clr;
  logic        w_unused_bits;

  assign w_rd_act = ~cs_n & ~rd_n;
  assign w_wr_act = ~cs_n & ~wr_n;
  assign w_wr_stb = w_wr_act & ~r_wr_act_d;
  assign w_rd_end = ~w_rd_act & r_rd_act_d;

  // Only the low MCR bits are stored; upper write-data bits are don't-care.
  assign w_unused_bits = ^datain;

  // Register strobes for edge detection and remember which register a read targeted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_act_d <= 1'b0;
      r_wr_act_d <= 1'b0;
      r_rd_addr  <= 2'd0;
    end else begin
      r_rd_act_d <= w_rd_act;
      r_wr_act_d <= w_wr_act;
      if (w_rd_act) r_rd_addr <= addr;
    end
  end

  assign w_msr_clr = w_rd_end & (r_rd_addr == 2'd2);
  assign w_lsr_clr = w_rd_end & (r_rd_addr == 2'd3);
  assign w_thr_wr  = w_wr_stb & (addr == 2'd0);

`ifdef UART_LOOPBACK_EN
  logic r_loop;

  // Loop-enable bit of MCR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_loop <= 1'b0;
    else if (w_wr_stb && (addr == 2'd1))   r_loop <= datain[4];
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // MCR: dtr, rts and the two interrupt enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_mcr <= 4'd0;
    else if (w_wr_stb && (addr == 2'd1))   r_mcr <= datain[3:0];
  end

  assign rts = r_mcr[1] & ~w_loop;
  assign dtr = r_mcr[0] & ~w_loop;

  // In loopback the modem status comes from our own rts/dtr; dcd/ri read 0.
  assign w_modem_raw = w_loop ? {2'b00, r_mcr[0], r_mcr[1]} : {dcd, ri, dsr, cts};

  // Synchronise modem status into clk domain and keep last value for change detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'd0;
      r_stat_prev <= 4'd0;
    end else begin
      r_sync[0] <= w_modem_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_stat_prev <= w_stat;
    end
  end

  assign w_stat = r_sync[SYNC_STAGES-1];
  // {ddcd, teri, ddsr, dcts}; teri only on ri falling
  assign w_delta_ev = {w_stat[3] ^ r_stat_prev[3],
                       r_stat_prev[2] & ~w_stat[2],
                       w_stat[1] ^ r_stat_prev[1],
                       w_stat[0] ^ r_stat_prev[0]};

  // Delta bits: cleared by MSR read, a same-cycle change keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_delta <= 4'd0;
    else        r_delta <= (w_msr_clr ? 4'd0 : r_delta) | w_delta_ev;
  end

  assign w_msr8 = {w_stat, r_delta};

  // RX FIFO control
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push_req  = r_lb_push | (rx_valid & ~w_loop);
  assign w_push_data = r_lb_push ? r_thr : rx_data;
  assign w_pop       = w_rd_end & (r_rd_addr == 2'd0) & ~w_empty;
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_rx_ovr_ev = w_push_req & w_full & ~w_pop;

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  // FIFO pointers, occupancy and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rx_ovr <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rx_ovr <= (w_lsr_clr ? 1'b0 : r_rx_ovr) | w_rx_ovr_ev;
    end
  end

  // An ack in the same cycle as a write frees the THR, so the new byte is taken.
  assign w_tx_ovr_ev = w_thr_wr & ~w_loop & r_tx_load & ~tx_ack;

  // THR, load handshake, loopback push request and tx overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr     <= '0;
      r_tx_load <= 1'b0;
      r_lb_push <= 1'b0;
      r_tx_ovr  <= 1'b0;
    end else begin
      r_lb_push <= w_thr_wr & w_loop;
      if (w_thr_wr && w_loop) begin
        r_thr <= datain;
      end else if (w_thr_wr && (!r_tx_load || tx_ack)) begin
        r_thr     <= datain;
        r_tx_load <= 1'b1;
      end else if (tx_ack) begin
        r_tx_load <= 1'b0;
      end
      r_tx_ovr <= (w_lsr_clr ? 1'b0 : r_tx_ovr) | w_tx_ovr_ev;
    end
  end

  assign tx_data = r_thr;
  assign tx_load = r_tx_load & ~w_loop;

  // Interrupt is registered from current flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= (r_mcr[2] & ~w_empty) | (r_mcr[3] & (|r_delta));
  end

  assign irq = r_irq;

  assign w_lsr    = {r_tx_ovr, r_tx_load, r_rx_ovr, w_full, ~w_empty};
  assign w_mcr_rd = {w_loop, r_mcr};

  // Read mux; bus is driven only while the read strobe is active.
  always_comb begin
    w_rdata = '0;
    case (addr)
      2'd0:    w_rdata = w_empty ? '0 : r_mem[r_rptr];
      2'd1:    w_rdata = DATA_W'(w_mcr_rd);
      2'd2:    w_rdata = w_msr8[DATA_W-1:0];
      default: w_rdata = DATA_W'(w_lsr);
    endcase
    dataout = w_rd_act ? w_rdata : '0;
    data_en = w_rd_act;
  end

endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Scoreboard bench for uart_ctrl_fifo: read accesses queue their expected
// data; a monitor compares whenever the DUT enables its bus driver.
module tb_uart_ctrl_fifo;
  localparam int DW = 8, DEPTH = 16, SS = 2;

  logic clk = 1'b0;
  logic rst_n, cs_n, wr_n, rd_n, data_en;
  logic [1:0] addr;
  logic [DW-1:0] datain, dataout, rx_data, tx_data;
  logic cts, dsr, dcd, ri, rx_valid, tx_load, tx_ack, rts, dtr, irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  uart_ctrl_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .datain(datain), .dataout(dataout), .data_en(data_en),
    .cts(cts), .dsr(dsr), .dcd(dcd), .ri(ri),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ack(tx_ack),
    .rts(rts), .dtr(dtr), .irq(irq)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: one comparison per bus read, on the first cycle data_en is high
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_en && !prev) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: got %h expected none", dataout);
        end else begin
          e = q.pop_front();
          chk(e.name, dataout, e.val);
        end
      end
      prev = data_en;
    end
  end

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm,
                    input bit push_end = 1'b0, input logic [7:0] pv = 8'h00);
    exp_t t;
    t.name = nm;
    t.val  = e;
    q.push_back(t);
    @(posedge clk); #1;
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1; rd_n = 1'b1;
    if (push_end) begin rx_valid = 1'b1; rx_data = pv; end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit ack = 1'b0);
    @(posedge clk); #1;
    addr = a; datain = d; cs_n = 1'b0; wr_n = 1'b0; tx_ack = ack;
    @(posedge clk); #1;
    tx_ack = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] v);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = v;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic ack();
    @(posedge clk); #1;
    tx_ack = 1'b1;
    @(posedge clk); #1;
    tx_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; addr = 2'd0;
    datain = '0; rx_data = '0; rx_valid = 1'b0; tx_ack = 1'b0;
    cts = 1'b0; dsr = 1'b0; dcd = 1'b0; ri = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_dataout", dataout, 8'h00);
    chk("rst_data_en", {7'd0, data_en}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_load", {7'd0, tx_load}, 8'h00);
    chk("rst_rts", {7'd0, rts}, 8'h00);
    chk("rst_dtr", {7'd0, dtr}, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rd(2'd3, 8'h00, "lsr_reset");
    rd(2'd2, 8'h00, "msr_reset");

    // basic FIFO order and empty read
    push(8'hA5);
    push(8'h3C);
    rd(2'd3, 8'h01, "lsr_two");
    rd(2'd0, 8'hA5, "fifo_1st");
    rd(2'd3, 8'h01, "lsr_one");
    rd(2'd0, 8'h3C, "fifo_2nd");
    rd(2'd3, 8'h00, "lsr_drained");
    rd(2'd0, 8'h00, "empty_read");
    rd(2'd3, 8'h00, "lsr_no_underflow");

    // overflow: 17th byte dropped
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    rd(2'd3, 8'h07, "lsr_overrun");
    rd(2'd3, 8'h03, "lsr_ovr_cleared");
    // pop and push on the same edge while full: no overrun
    rd(2'd0, 8'h10, "fifo_pop_push_full", 1'b1, 8'hEE);
    rd(2'd3, 8'h03, "lsr_full_no_ovr");
    for (int i = 1; i < 16; i++) rd(2'd0, 8'h10 + 8'(i), "fifo_drain");
    rd(2'd0, 8'hEE, "fifo_late_push");
    rd(2'd3, 8'h00, "lsr_after_drain");

    // TX holding register
    wr(2'd0, 8'h55);
    chk("tx_data_55", tx_data, 8'h55);
    chk("tx_load_set", {7'd0, tx_load}, 8'h01);
    wr(2'd0, 8'h66);
    chk("tx_data_kept", tx_data, 8'h55);
    rd(2'd3, 8'h18, "lsr_tx_ovr");
    rd(2'd3, 8'h08, "lsr_tx_ovr_clr");
    ack();
    chk("tx_load_after_ack", {7'd0, tx_load}, 8'h00);
    ack();
    chk("tx_ack_idle", {7'd0, tx_load}, 8'h00);
    rd(2'd3, 8'h00, "lsr_tx_idle");
    wr(2'd0, 8'h77);
    chk("tx_load_77", {7'd0, tx_load}, 8'h01);
    wr(2'd0, 8'h88, 1'b1);
    chk("tx_data_wr_ack", tx_data, 8'h88);
    chk("tx_load_wr_ack", {7'd0, tx_load}, 8'h01);
    rd(2'd3, 8'h08, "lsr_wr_ack");
    ack();
    chk("tx_load_final", {7'd0, tx_load}, 8'h00);

    // modem control
    wr(2'd1, 8'h03);
    chk("rts_on", {7'd0, rts}, 8'h01);
    chk("dtr_on", {7'd0, dtr}, 8'h01);
    rd(2'd1, 8'h03, "mcr_03");
    wr(2'd1, 8'h0C);
    rd(2'd1, 8'h0C, "mcr_0c");
    chk("rts_off", {7'd0, rts}, 8'h00);

    // cts change -> dcts, irq
    @(posedge clk); #1 cts = 1'b1;
    repeat (SS + 2) @(posedge clk);
    #1;
    chk("irq_dcts", {7'd0, irq}, 8'h01);
    rd(2'd2, 8'h11, "msr_dcts");
    chk("irq_latency", {7'd0, irq}, 8'h01);
    @(posedge clk); #1;
    chk("irq_cleared", {7'd0, irq}, 8'h00);
    rd(2'd2, 8'h10, "msr_cleared");

    // ri rise: no delta; ri fall: teri
    ri = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd(2'd2, 8'h50, "msr_ri_high");
    chk("irq_ri_rise", {7'd0, irq}, 8'h00);
    ri = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_teri", {7'd0, irq}, 8'h01);
    rd(2'd2, 8'h14, "msr_teri");
    rd(2'd2, 8'h10, "msr_teri_clr");

    dsr = 1'b1; dcd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd(2'd2, 8'hBA, "msr_dsr_dcd");
    rd(2'd2, 8'hB0, "msr_dsr_dcd_clr");

    // rx interrupt
    wr(2'd1, 8'h04);
    chk("irq_rx_idle", {7'd0, irq}, 8'h00);
    push(8'h77);
    chk("irq_rx_latency", {7'd0, irq}, 8'h00);
    @(posedge clk); #1;
    chk("irq_rx", {7'd0, irq}, 8'h01);
    rd(2'd0, 8'h77, "fifo_rx_irq");
    @(posedge clk); #1;
    chk("irq_rx_clr", {7'd0, irq}, 8'h00);
    wr(2'd1, 8'h00);

    // reset mid-access aborts read and write
    cts = 1'b0; dsr = 1'b0; dcd = 1'b0;
    push(8'h99);
    begin
      exp_t t;
      t.name = "aborted_read";
      t.val  = 8'h99;
      q.push_back(t);
    end
    @(posedge clk); #1;
    addr = 2'd0; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1;
    addr = 2'd0; datain = 8'hC3; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx_load", {7'd0, tx_load}, 8'h00);
    chk("abort_tx_data", tx_data, 8'h00);
    rd(2'd3, 8'h00, "lsr_after_abort");

`ifdef UART_LOOPBACK_EN
    wr(2'd1, 8'h13);
    chk("lb_rts_pin", {7'd0, rts}, 8'h00);
    chk("lb_dtr_pin", {7'd0, dtr}, 8'h00);
    rd(2'd1, 8'h13, "lb_mcr");
    wr(2'd0, 8'h5A);
    chk("lb_tx_load", {7'd0, tx_load}, 8'h00);
    rd(2'd3, 8'h01, "lb_lsr");
    rd(2'd0, 8'h5A, "lb_fifo");
    rd(2'd2, 8'h33, "lb_msr");
    push(8'h11);
    rd(2'd3, 8'h00, "lb_rx_ignored");
`else
    wr(2'd1, 8'h13);
    rd(2'd1, 8'h03, "mcr_no_loop");
    chk("rts_no_loop", {7'd0, rts}, 8'h01);
`endif

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
